// File: rtl/bcd2bin_seq.sv
// ============================================================================
// Module   : bcd2bin_seq
// Brief    : Sequential signed 4-digit BCD to 11-bit two's-complement converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2bin_seq #(
    parameter int MAX_MAG = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bcd_vld,
    input  logic [16:0] bcd,
    output logic        bcd_rdy,
    output logic        bin_vld,
    output logic [10:0] bin,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic [13:0] C_MAX_MAG = 14'(MAX_MAG);

    state_t      r_state;
    state_t      w_next;
    logic [16:0] r_word;
    logic [13:0] r_acc;
    logic [1:0]  r_cnt;
    logic        r_dig_err;

    logic [3:0]  w_digit;
    logic [13:0] w_acc_next;
    logic        w_err;
    logic [10:0] w_bin;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bcd_vld) w_next = CONV;
            CONV:    if (r_cnt == 2'd3) w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bcd_rdy = (r_state == IDLE);

    // Most-significant digit first: counter 0 selects thousands.
    always_comb begin
        w_digit = 4'd0;
        case (r_cnt)
            2'd0: w_digit = r_word[15:12];
            2'd1: w_digit = r_word[11:8];
            2'd2: w_digit = r_word[7:4];
            2'd3: w_digit = r_word[3:0];
            default: w_digit = 4'd0;
        endcase
    end

    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + {10'd0, w_digit};

    always_comb begin
        w_err = r_dig_err || (r_acc > C_MAX_MAG);
        w_bin = 11'd0;
        if (!w_err) begin
            w_bin = r_word[16] ? (~r_acc[10:0]) + 11'd1 : r_acc[10:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word    <= 17'd0;
            r_acc     <= 14'd0;
            r_cnt     <= 2'd0;
            r_dig_err <= 1'b0;
            bin_vld   <= 1'b0;
            bin       <= 11'd0;
            err       <= 1'b0;
        end else begin
            bin_vld <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bcd_vld) begin
                        r_word    <= bcd;
                        r_acc     <= 14'd0;
                        r_cnt     <= 2'd0;
                        r_dig_err <= 1'b0;
                    end
                end
                CONV: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 2'd1;
                    if (w_digit > 4'd9) begin
                        r_dig_err <= 1'b1;
                    end
                end
                OUT: begin
                    bin_vld <= 1'b1;
                    bin     <= w_bin;
                    err     <= w_err;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/bcd2bin_seq.md
BCD2BIN_SEQ -- requirements
Module: bcd2bin_seq

Interface
REQ-001 The block SHALL have one parameter: MAX_MAG, default 1023, the largest magnitude accepted without error.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port clk SHALL be an input, 1 bit: rising-edge clock.
REQ-004 Port rst SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-005 Port bcd_vld SHALL be an input, 1 bit: input word valid.
REQ-006 Port bcd SHALL be an input, 17 bits: [16] sign (1 = negative), [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-007 Port bcd_rdy SHALL be an output, 1 bit: block idle and able to accept a word.
REQ-008 Port bin_vld SHALL be an output, 1 bit: one-cycle result strobe.
REQ-009 Port bin SHALL be an output, 11 bits: two's-complement result.
REQ-010 Port err SHALL be an output, 1 bit: result invalid; qualified by bin_vld.

Function
REQ-011 The FSM SHALL have three states: IDLE, CONV, OUT.
REQ-012 bcd_rdy SHALL be 1 in IDLE and 0 in CONV and OUT; it is a combinational decode of the state.
REQ-013 Acceptance SHALL occur on a rising edge (E0) in IDLE with bcd_vld=1: the block captures bcd into an internal register, clears the accumulator and the digit counter, and moves to CONV.
REQ-014 bcd_vld SHALL be ignored whenever bcd_rdy=0; the captured word is unaffected by later input changes.
REQ-015 CONV SHALL process one digit per edge, most-significant first (E1 thousands .. E4 ones): acc <= acc*10 + digit.
REQ-016 The accumulator SHALL be 14 bits, wide enough for 9999 with no overflow; *10 SHALL be implemented as (acc<<3)+(acc<<1).
REQ-017 Any digit > 9 SHALL set a sticky digit-error flag for the current word.
REQ-018 The 2-bit digit counter SHALL run 0..3; at count 3 (E4) the state SHALL move to OUT.
REQ-019 At E5 (state OUT) the block SHALL load its registered outputs: bin_vld=1, err=(digit error OR acc>MAX_MAG); bin=0 when err=1, else bin=acc[10:0] for sign 0, else bin=(~acc[10:0])+1 for sign 1. The state SHALL then return to IDLE.
REQ-020 Negative zero (sign 1, all digits 0) SHALL give bin=0 and err=0.
REQ-021 bin_vld SHALL be high for exactly the one cycle following E5 and low otherwise.
REQ-022 bin and err SHALL hold their last values until the next result is loaded.
REQ-023 Latency SHALL be 5 edges from acceptance to bin_vld high, and throughput SHALL be one word per 6 cycles.
REQ-024 bcd_rdy=1 while bin_vld=1, so a new word may be accepted in the same cycle that the result strobe is high.

Reset
REQ-025 While rst=1, the block SHALL enter IDLE, clear the accumulator, counter, captured word and error flag, and drive bcd_rdy=1, bin_vld=0, bin=0, err=0.
REQ-026 Reset asserted during CONV or OUT SHALL abort the conversion with no bin_vld pulse.
REQ-027 The first acceptance after reset SHALL occur on the first rising edge with rst=0 and bcd_vld=1.

Verification
REQ-028 Positive value: bcd=17'h00999 -> bin_vld pulses 5 edges later with bin=11'h3E7 and err=0; bcd_rdy is low for 5 cycles.
REQ-029 Negative values: bcd=17'h11023 -> bin=11'h401, err=0; bcd=17'h10000 -> bin=11'h000, err=0.
REQ-030 Errors: bcd=17'h01024 -> err=1, bin=0; bcd=17'h0012A -> err=1, bin=0; bcd=17'h0F000 -> err=1, bin=0.
REQ-031 Busy input: hold bcd_vld=1 continuously while changing bcd every cycle -> only the words present in the cycles where bcd_rdy=1 are converted, exactly one bin_vld per 6 cycles, and each result matches its captured word.
REQ-032 Reset mid-operation: accept 17'h00555, assert rst at E2 -> no bin_vld pulse, all outputs read 0 and bcd_rdy=1; then accept 17'h10111 -> bin=11'h791, err=0.
REQ-033 Exhaustive sweep: all sign/value pairs from -1023 to +1023 -> bin equals the signed value and err=0; a round trip through the existing binary-to-BCD converter returns the original 11-bit input.
